led_display_arbiter: RTL



---
 rtl/led_display_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/led_display_arbiter.sv
// rtl/led_display_arbiter.sv - round-robin time-sharing of the hex display between debug sources
// Optional build macro: LED_SRC_TAG_EN (leftmost display digit shows the granted source index)
module led_display_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int SRC_W        = 2,
  parameter int DWELL_CYCLES = 25000000,
  parameter int CNT_W        = 25
) (
  input  logic                    clkg,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      src_req,
  input  logic [32*NUM_SRC-1:0]   src_data,
  output logic [NUM_SRC-1:0]      src_ack,
  input  logic                    hold_i,
  output logic [31:0]             disp_result,
  output logic [SRC_W-1:0]        disp_src,
  output logic                    disp_valid
);

  typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

  state_t             state;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   grant_q;
  logic [SRC_W-1:0]   grant_c;
  logic               req_found;
  logic [CNT_W-1:0]   dwell_cnt;
  logic [NUM_SRC-1:0] req_rot;
  logic [31:0]        sel_data;
  logic [31:0]        cap_data;
  logic [NUM_SRC-1:0] ack_c;
  logic [SRC_W-1:0]   ptr_next;

  // Rotate requests so bit 0 is the source at rr_ptr; the first set bit wins
  assign req_rot = NUM_SRC'({src_req, src_req} >> rr_ptr);

  // Round-robin search: offset from rr_ptr, folded back into 0..NUM_SRC-1
  always_comb begin
    int sum;
    grant_c   = '0;
    req_found = 1'b0;
    sum       = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!req_found && req_rot[i]) begin
        req_found = 1'b1;
        sum       = int'(rr_ptr) + i;
        if (sum >= NUM_SRC) sum = sum - NUM_SRC;
        grant_c   = SRC_W'(sum);
      end
    end
  end

  // Select the granted source's word and build its one-hot ack
  always_comb begin
    sel_data = '0;
    ack_c    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == SRC_W'(i)) begin
        sel_data = src_data[32*i +: 32];
        ack_c[i] = 1'b1;
      end
    end
  end

  // Captured display word, optionally tagged with the source index
  always_comb begin
    cap_data = sel_data;
`ifdef LED_SRC_TAG_EN
    cap_data[31:28] = 4'(grant_q);
`else
    cap_data[31:28] = sel_data[31:28];
`endif
  end

  assign ptr_next = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + SRC_W'(1);

  // Arbitrate, capture for one LOAD cycle, then dwell in SHOW
  always_ff @(posedge clkg or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_q     <= '0;
      dwell_cnt   <= '0;
      disp_result <= '0;
      disp_src    <= '0;
      disp_valid  <= 1'b0;
      src_ack     <= '0;
    end else begin
      src_ack <= '0;
      case (state)
        IDLE: begin
          if (req_found) begin
            grant_q <= grant_c;
            state   <= LOAD;
          end
        end
        LOAD: begin
          disp_result <= cap_data;
          disp_src    <= grant_q;
          disp_valid  <= 1'b1;
          src_ack     <= ack_c;
          dwell_cnt   <= CNT_W'(DWELL_CYCLES - 1);
          rr_ptr      <= ptr_next;
          state       <= SHOW;
        end
        SHOW: begin
          if (!hold_i) begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - CNT_W'(1);
            end else if (req_found) begin
              grant_q <= grant_c;
              state   <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
